port_pkt_forwarder: RTL and testbench

- Consumes the one-hot grant from the port arbitrator.
- Streams the granted port's packet from that port's show-ahead input FIFO to the shared cache write path. The packet is a header word followed by a payload.
- Signals end-of-packet back to the arbitrator so the next grant can be issued.
- Sits directly downstream of the arbitrator and upstream of the cache write controller.

---
 rtl/mpc_pkg.sv | 14 +
 rtl/onehot_lsb_enc.sv | 22 ++
 rtl/port_pkt_forwarder.sv | 123 ++++++++++++
 tb/tb_port_pkt_forwarder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_pkg.sv
// Shared types for the port packet forwarder: FSM state encoding and header field layout.
package mpc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        DATA  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Payload length occupies the low bits of the header word.
    localparam int LEN_LSB = 0;

endpackage

// File: rtl/onehot_lsb_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest asserted request bit.
module onehot_lsb_enc #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          vld
);

    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_pkt_forwarder.sv
// Streams the granted port's packet (header + payload) from its show-ahead FIFO to the cache write path.
//
// state | meaning
// IDLE  | waiting for a grant from the arbitrator
// HDR   | popping the header word of the granted port
// DATA  | popping payload words, cnt = words still to pop
// FLUSH | last word held in the output register until accepted
module port_pkt_forwarder
    import mpc_pkg::*;
#(
    parameter int PORTNUM = 16,
    parameter int DWIDTH  = 32,
    parameter int LENW    = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [PORTNUM-1:0]        i_resp,
    input  logic [PORTNUM*DWIDTH-1:0] i_port_data,
    input  logic [PORTNUM-1:0]        i_port_vld,
    output logic [PORTNUM-1:0]        o_port_rd,
    output logic [DWIDTH-1:0]         o_data,
    output logic                      o_vld,
    output logic                      o_sop,
    output logic                      o_eop,
    input  logic                      i_ready,
    output logic                      o_arb_eop,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int IW = $clog2(PORTNUM);

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     grant_idx;
    logic              grant_vld;
    logic              grant_onehot;
    logic [LENW-1:0]   cnt;
    logic [LENW-1:0]   hdr_len;
    logic [DWIDTH-1:0] head_data;
    logic              head_vld;
    logic              pop_ok;
    logic              pop;
    logic              xfer;
    logic              last_xfer;

    onehot_lsb_enc #(.N(PORTNUM), .IW(IW)) u_grant_enc (
        .req (i_resp),
        .idx (grant_idx),
        .vld (grant_vld)
    );

    assign grant_onehot = grant_vld && (i_resp == (PORTNUM'(1) << grant_idx));
    assign head_data    = i_port_data[idx*DWIDTH +: DWIDTH];
    assign head_vld     = i_port_vld[idx];
    assign hdr_len      = head_data[LEN_LSB +: LENW];
    assign xfer         = o_vld & i_ready;
    assign last_xfer    = o_vld & o_eop & i_ready;
    // A pop is allowed when the output register is empty or being drained this cycle.
    assign pop_ok       = head_vld & (~o_vld | i_ready);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = HDR;
            HDR:     if (pop_ok) state_nxt = (hdr_len == '0) ? FLUSH : DATA;
            DATA:    if (pop_ok && cnt == LENW'(1)) state_nxt = FLUSH;
            FLUSH:   if (last_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_port_rd = '0;
        pop       = 1'b0;
        o_busy    = (state != IDLE);
        if ((state == HDR || state == DATA) && pop_ok) begin
            pop            = 1'b1;
            o_port_rd[idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            o_data    <= '0;
            o_vld     <= 1'b0;
            o_sop     <= 1'b0;
            o_eop     <= 1'b0;
            o_arb_eop <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_arb_eop <= (state == FLUSH) && last_xfer;
            // Grants are only legal (and one-hot) while idle.
            o_err     <= (state == IDLE) ? (grant_vld && !grant_onehot) : grant_vld;
            if (state == IDLE && grant_vld) begin
                idx <= grant_idx;
            end
            if (pop) begin
                o_data <= head_data;
                o_vld  <= 1'b1;
                o_sop  <= (state == HDR);
                o_eop  <= (state == HDR) ? (hdr_len == '0) : (cnt == LENW'(1));
                cnt    <= (state == HDR) ? hdr_len : cnt - LENW'(1);
            end else if (xfer) begin
                o_vld <= 1'b0;
                o_sop <= 1'b0;
                o_eop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_port_pkt_forwarder.sv
// Directed and randomized checks of port_pkt_forwarder against a packet-level reference model.
module tb_port_pkt_forwarder;

    localparam int P  = 16;
    localparam int DW = 32;
    localparam int LW = 8;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [P-1:0]      i_resp;
    logic [P*DW-1:0]   i_port_data;
    logic [P-1:0]      i_port_vld;
    logic [P-1:0]      o_port_rd;
    logic [DW-1:0]     o_data;
    logic              o_vld, o_sop, o_eop, i_ready, o_arb_eop, o_busy, o_err;

    always #5 i_clk = ~i_clk;

    port_pkt_forwarder #(.PORTNUM(P), .DWIDTH(DW), .LENW(LW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_resp(i_resp), .i_port_data(i_port_data),
        .i_port_vld(i_port_vld), .o_port_rd(o_port_rd), .o_data(o_data), .o_vld(o_vld),
        .o_sop(o_sop), .o_eop(o_eop), .i_ready(i_ready), .o_arb_eop(o_arb_eop),
        .o_busy(o_busy), .o_err(o_err)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] src_q[$];
    int            src_port = 0;
    int            cur_port = 0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         ready_mode = 0;
    int         ready_base = 0;
    int         bub_start  = -1;
    int         bub_len    = 0;
    bit         rand_bub   = 0;
    int         rst_cycle  = -1;
    int         inj_cycle  = -1;
    logic [P-1:0] inj_resp = '0;

    bit            in_pkt = 0, exp_err = 0, exp_arb = 0, hold = 0, rst_prev = 0;
    logic [DW-1:0] hold_d;
    logic          hold_sop, hold_eop;

    int grant_cyc, rd_first, sop_cyc, eop_cyc, arb_cyc, err_cyc, rd_cnt, xfer_cnt, arb_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        bit bub;
        i_rst_n = (cyc == rst_cycle) ? 1'b0 : 1'b1;
        i_resp  = (cyc == inj_cycle) ? inj_resp : '0;
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ((cyc - ready_base) % 3 == 0);
            default: i_ready = ($urandom_range(0, 3) != 0);
        endcase
        bub = (cyc >= bub_start && cyc < bub_start + bub_len) ||
              (rand_bub && $urandom_range(0, 3) == 0);
        for (int k = 0; k < P; k++) begin
            if (k == src_port) begin
                i_port_vld[k] = (src_q.size() != 0) && !bub;
                i_port_data[k*DW +: DW] = (src_q.size() != 0) ? src_q[0] : '0;
            end else begin
                i_port_vld[k] = 1'($urandom_range(0, 1));
                i_port_data[k*DW +: DW] = $urandom;
            end
        end
    endtask

    task automatic step();
        logic [P-1:0] rd;
        logic         xf;
        bit           rst_now;
        word_t        w;
        @(negedge i_clk);
        rd      = o_port_rd;
        rst_now = !i_rst_n;
        if (rst_prev) begin
            chk("rst_vld", o_vld, 0);
            chk("rst_sop", o_sop, 0);
            chk("rst_eop", o_eop, 0);
            chk("rst_data", o_data, 0);
            chk("rst_rd", rd, 0);
        end
        chk("busy", o_busy, in_pkt);
        chk("err", o_err, exp_err);
        chk("arb_eop", o_arb_eop, exp_arb);
        chk("rd_atmost1", $countones(rd) <= 1, 1);
        chk("rd_port", rd & ~(P'(1) << cur_port), 0);
        chk("rd_stall", (rd != 0) && o_vld && !i_ready, 0);
        chk("rd_novld", rd & ~i_port_vld, 0);
        if (hold) begin
            chk("hold_vld", o_vld, 1);
            chk("hold_data", o_data, hold_d);
            chk("hold_sop", o_sop, hold_sop);
            chk("hold_eop", o_eop, hold_eop);
        end
        if (o_arb_eop) begin
            arb_cnt++;
            if (arb_cyc < 0) arb_cyc = cyc;
        end
        if (o_err && err_cyc < 0) err_cyc = cyc;
        if (rd[src_port]) begin
            rd_cnt++;
            if (rd_first < 0) rd_first = cyc;
        end
        xf = o_vld && i_ready;
        if (xf) begin
            xfer_cnt++;
            chk("xfer_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("xfer_data", o_data, w.d);
                chk("xfer_sop", o_sop, w.sop);
                chk("xfer_eop", o_eop, w.eop);
            end
            if (o_sop && sop_cyc < 0) sop_cyc = cyc;
            if (o_eop) eop_cyc = cyc;
        end
        if (rst_now) begin
            in_pkt  = 0;
            exp_err = 0;
            exp_arb = 0;
            hold    = 0;
        end else begin
            exp_err = (i_resp != 0) && (in_pkt || $countones(i_resp) != 1);
            exp_arb = xf && o_eop;
            if (i_resp != 0 && !in_pkt) in_pkt = 1;
            else if (xf && o_eop) in_pkt = 0;
            hold     = o_vld && !i_ready;
            hold_d   = o_data;
            hold_sop = o_sop;
            hold_eop = o_eop;
        end
        rst_prev = rst_now;
        @(posedge i_clk);
        #1;
        if (rd[src_port] && src_q.size() != 0) void'(src_q.pop_front());
        cyc++;
        drive_inputs();
    endtask

    task automatic grant(input logic [P-1:0] resp, input int port, input int len);
        logic [DW-1:0] r, hdr;
        word_t         w;
        r   = $urandom;
        hdr = {r[DW-1:LW], LW'(len)};
        src_port = port;
        cur_port = port;
        src_q.push_back(hdr);
        w.d = hdr; w.sop = 1'b1; w.eop = (len == 0);
        exp_q.push_back(w);
        for (int i = 1; i <= len; i++) begin
            r = $urandom;
            src_q.push_back(r);
            w.d = r; w.sop = 1'b0; w.eop = (i == len);
            exp_q.push_back(w);
        end
        rd_first = -1; sop_cyc = -1; eop_cyc = -1; arb_cyc = -1; err_cyc = -1;
        rd_cnt = 0; xfer_cnt = 0; arb_cnt = 0;
        drive_inputs();
        i_resp    = resp;
        grant_cyc = cyc;
    endtask

    task automatic finish_pkt(input int len);
        int n;
        n = 0;
        while (arb_cnt == 0 && n < 400) begin
            step();
            n++;
        end
        step();
        step();
        chk("pkt_arb_count", arb_cnt, 1);
        chk("pkt_q_empty", exp_q.size(), 0);
        chk("pkt_rd_count", rd_cnt, len + 1);
        chk("pkt_xfer_count", xfer_cnt, len + 1);
        chk("pkt_arb_after_eop", arb_cyc, eop_cyc + 1);
    endtask

    initial begin
        logic [P-1:0] m, resp;
        int           port, len;
        i_rst_n = 1'b0; i_resp = '0; i_ready = 1'b0; i_port_vld = '0; i_port_data = '0;
        @(posedge i_clk);
        #1;
        rst_prev = 1;
        cyc = 1;
        drive_inputs();
        step();
        step();

        // Nominal 4-word payload on port 3.
        grant(16'h0008, 3, 4);
        finish_pkt(4);
        chk("t1_rd", rd_first, grant_cyc + 1);
        chk("t1_sop", sop_cyc, grant_cyc + 2);
        chk("t1_eop", eop_cyc, grant_cyc + 6);
        chk("t1_arb", arb_cyc, grant_cyc + 7);

        // Header-only packet on port 0.
        grant(16'h0001, 0, 0);
        finish_pkt(0);
        chk("t2_sop_eq_eop", eop_cyc, sop_cyc);
        chk("t2_arb", arb_cyc, grant_cyc + 3);

        // Backpressure with ready pattern 1,0,0 on port 15.
        ready_mode = 1;
        grant(16'h8000, 15, 3);
        ready_base = grant_cyc + 2;
        finish_pkt(3);
        ready_mode = 0;

        // Source bubble of two cycles on port 5.
        grant(16'h0020, 5, 5);
        bub_start = grant_cyc + 5;
        bub_len   = 2;
        finish_pkt(5);
        chk("t4_eop", eop_cyc, grant_cyc + 9);
        bub_len = 0;

        // Non-one-hot grant in IDLE forwards the lowest port.
        grant(16'h0120, 5, 2);
        finish_pkt(2);
        chk("t5a_err", err_cyc, grant_cyc + 1);

        // Grant during DATA flags an error and leaves the packet intact.
        grant(16'h0008, 3, 6);
        inj_cycle = grant_cyc + 4;
        inj_resp  = 16'h0001;
        finish_pkt(6);
        chk("t5b_err", err_cyc, grant_cyc + 5);
        chk("t5b_eop", eop_cyc, grant_cyc + 8);
        inj_cycle = -1;

        // Reset mid-DATA abandons the packet.
        grant(16'h0080, 7, 6);
        rst_cycle = grant_cyc + 4;
        while (cyc <= grant_cyc + 8) step();
        chk("t6_no_arb", arb_cnt, 0);
        rst_cycle = -1;
        src_q.delete();
        exp_q.delete();
        grant(16'h0200, 9, 3);
        finish_pkt(3);
        chk("t6_sop", sop_cyc, grant_cyc + 2);
        chk("t6_arb", arb_cyc, grant_cyc + 6);

        // Random packets with random backpressure and bubbles.
        ready_mode = 2;
        rand_bub   = 1;
        for (int p = 0; p < 25; p++) begin
            port = $urandom_range(0, P - 1);
            len  = $urandom_range(0, 12);
            resp = P'(1) << port;
            if ($urandom_range(0, 3) == 0) begin
                m    = (P'(2) << port) - P'(1);
                resp = resp | (P'($urandom) & ~m);
            end
            grant(resp, port, len);
            finish_pkt(len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
